// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_pkg
// Description : Shared definitions for the iterative multiply/divide unit:
//               operation encodings, FSM state type, iteration count and the
//               divide-by-zero quotient value.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PREP = 2'd1,
    S_ITER = 2'd2,
    S_FIX  = 2'd3
  } state_e;

  localparam int          ITER_COUNT = 32;
  localparam logic [31:0] DIV0_LO    = 32'hFFFF_FFFF;

  // Codes 0..3 are the long-latency operations; 4..7 complete in IDLE.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op <= OP_DIVU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_addsub.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_addsub
// Description : 33-bit adder/subtractor with carry-out, shared by the
//               multiply add step and the divide trial subtract.
// Ports       : a_i, b_i  - 33-bit operands
//               sub_i     - 1: a_i - b_i, 0: a_i + b_i
//               sum_o     - 33-bit result
//               cout_o    - carry-out (for subtract: 1 means a_i >= b_i)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_addsub (
  input  logic [32:0] a_i,
  input  logic [32:0] b_i,
  input  logic        sub_i,
  output logic [32:0] sum_o,
  output logic        cout_o
);

  // Subtract as a + ~b + 1 so the carry-out doubles as the "no borrow" flag.
  assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i ^ {33{sub_i}}} + {33'd0, sub_i};

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Iterative 32-bit multiply/divide unit with HI/LO registers.
//               One bit per cycle: shift-add multiply, restoring divide.
// Ports       : clk_i, reset_i     - clock, synchronous active-high reset
//               start_i, op_i      - issue request and operation (IDLE only)
//               opa_i, opb_i       - rs / rt operands
//               busy_o             - multiply/divide in flight
//               done_o             - one-cycle pulse after HI/LO update
//               hi_o, lo_o         - architectural HI / LO
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            reset_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] opa_i,
  input  logic [XLEN-1:0] opb_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [XLEN-1:0] hi_o,
  output logic [XLEN-1:0] lo_o
);

  state_e       state_q, state_d;
  logic [4:0]   cnt_q;
  logic [2:0]   op_q;
  logic [31:0]  opa_raw_q, opb_raw_q;
  logic [31:0]  mcand_q;      // multiplicand or divisor magnitude
  logic [63:0]  acc_q;        // {partial hi / remainder, multiplier / quotient}
  logic         neg_q;        // negate product or quotient
  logic         neg_rem_q;    // negate remainder
  logic         div0_q;
  logic [31:0]  hi_q, lo_q;
  logic         done_q;

  logic         is_div;
  logic         is_signed;
  logic         a_neg, b_neg;
  logic [31:0]  mag_a, mag_b;
  logic [32:0]  add_a, add_b, add_sum;
  logic         add_cout;
  logic [31:0]  new_rem;
  logic [63:0]  acc_step;
  logic [63:0]  prod_fix;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start_i && is_muldiv(op_i)) state_d = S_PREP;
      S_PREP: state_d = S_ITER;
      S_ITER: if (cnt_q == 5'(ITER_COUNT - 1)) state_d = S_FIX;
      S_FIX:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy_o = (state_q != S_IDLE);
    done_o = done_q;
  end

  assign hi_o = hi_q;
  assign lo_o = lo_q;

  // ---------------- datapath ----------------
  assign is_div    = op_q[1];
  assign is_signed = ~op_q[0];
  assign a_neg     = is_signed & opa_raw_q[31];
  assign b_neg     = is_signed & opb_raw_q[31];
  assign mag_a     = a_neg ? (32'd0 - opa_raw_q) : opa_raw_q;
  assign mag_b     = b_neg ? (32'd0 - opb_raw_q) : opb_raw_q;

  // Divide trial-subtracts the shifted remainder {rem, next dividend bit};
  // multiply adds the multiplicand into the upper accumulator half.
  always_comb begin
    add_b = {1'b0, mcand_q};
    if (is_div) add_a = acc_q[63:31];
    else        add_a = {1'b0, acc_q[63:32]};
  end

  muldiv_addsub u_addsub (
    .a_i    (add_a),
    .b_i    (add_b),
    .sub_i  (is_div),
    .sum_o  (add_sum),
    .cout_o (add_cout)
  );

  always_comb begin
    new_rem = add_cout ? add_sum[31:0] : acc_q[62:31];
    if (is_div)
      acc_step = {new_rem, acc_q[30:0], add_cout};
    else if (acc_q[0])
      acc_step = {add_sum, acc_q[31:1]};
    else
      acc_step = {1'b0, acc_q[63:32], acc_q[31:1]};
    prod_fix = neg_q ? (64'd0 - acc_q) : acc_q;
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      cnt_q     <= 5'd0;
      op_q      <= 3'd0;
      opa_raw_q <= 32'd0;
      opb_raw_q <= 32'd0;
      mcand_q   <= 32'd0;
      acc_q     <= 64'd0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
      done_q    <= 1'b0;
    end else begin
      done_q <= (state_q == S_FIX);
      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (is_muldiv(op_i)) begin
              op_q      <= op_i;
              opa_raw_q <= opa_i;
              opb_raw_q <= opb_i;
            end
            if (op_i == OP_MTHI) hi_q <= opa_i;
            if (op_i == OP_MTLO) lo_q <= opa_i;
          end
        end
        S_PREP: begin
          // Both operations start from {0, mag_a} with mag_b as the addend/divisor.
          acc_q     <= {32'd0, mag_a};
          mcand_q   <= mag_b;
          neg_q     <= a_neg ^ b_neg;
          neg_rem_q <= a_neg;
          div0_q    <= (opb_raw_q == 32'd0);
          cnt_q     <= 5'd0;
        end
        S_ITER: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + 5'd1;
        end
        S_FIX: begin
          if (is_div) begin
            if (div0_q) begin
              lo_q <= DIV0_LO;
              hi_q <= opa_raw_q;
            end else begin
              lo_q <= neg_q     ? (32'd0 - acc_q[31:0])  : acc_q[31:0];
              hi_q <= neg_rem_q ? (32'd0 - acc_q[63:32]) : acc_q[63:32];
            end
          end else begin
            hi_q <= prod_fix[63:32];
            lo_q <= prod_fix[31:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit: table of directed
//               multiply/divide vectors plus hand-written sequences for
//               moves, busy handling, back-to-back issue and reset abort.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] opa_i, opb_i;
  logic        busy_o, done_o;
  logic [31:0] hi_o, lo_o;

  int errors = 0;
  int checks = 0;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .start_i (start_i),
    .op_i    (op_i),
    .opa_i   (opa_i),
    .opb_i   (opb_i),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .hi_o    (hi_o),
    .lo_o    (lo_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one request; returns 1 time unit after the sampling edge E0.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    start_i = 1'b1; op_i = op; opa_i = a; opb_i = b;
    @(posedge clk_i); #1;
    start_i = 1'b0;
  endtask

  // Counts edges after E0 until done is seen; checks HI/LO hold mid-operation.
  task automatic wait_done(input string name, input logic [31:0] ph, input logic [31:0] pl,
                           output int lat);
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(posedge clk_i); #1;
      if (k == 10) begin
        chk({name, " busy mid"}, {63'd0, busy_o}, 64'd1);
        chk({name, " hold"}, {hi_o, lo_o}, {ph, pl});
      end
      if (done_o) lat = k;
    end
  endtask

  logic [31:0] m_hi, m_lo;
  int          lat;
  int          ndone;

  initial begin
    vecs[0] = '{"mult_neg3x7",  OP_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[1] = '{"multu_max",    OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{"div_neg7by2",  OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{"divu_100by7",  OP_DIVU,  32'd100,       32'd7,        32'h0000_0002, 32'h0000_000E};
    vecs[4] = '{"divu_by0",     OP_DIVU,  32'h0000_1234, 32'd0,        32'h0000_1234, 32'hFFFF_FFFF};
    vecs[5] = '{"div_ovf",      OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{"mult_minsq",   OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[7] = '{"div_7byneg2",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{"div_by0_s",    OP_DIV,   32'hFFFF_FFF9, 32'd0,        32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[9] = '{"multu_shift",  OP_MULTU, 32'h1234_5678, 32'h10,       32'h0000_0001, 32'h2345_6780};

    reset_i = 1'b1; start_i = 1'b0; op_i = 3'd0; opa_i = 32'd0; opb_i = 32'd0;
    repeat (3) @(posedge clk_i);
    #1 reset_i = 1'b0;
    chk("reset state", {hi_o, lo_o}, 64'd0);
    chk("reset busy/done", {62'd0, busy_o, done_o}, 64'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b);
      wait_done(vecs[i].name, m_hi, m_lo, lat);
      chk({vecs[i].name, " latency"}, 64'(lat), 64'd34);
      chk({vecs[i].name, " hi/lo"}, {hi_o, lo_o}, {vecs[i].hi, vecs[i].lo});
      m_hi = vecs[i].hi; m_lo = vecs[i].lo;
      @(posedge clk_i); #1;
      chk({vecs[i].name, " done pulse"}, {62'd0, busy_o, done_o}, 64'd0);
    end

    // Moves complete in IDLE, visible the next cycle, never busy.
    issue(OP_MTHI, 32'hDEAD_BEEF, 32'd0);
    chk("mthi", {hi_o, lo_o}, {32'hDEAD_BEEF, m_lo});
    chk("mthi busy", {62'd0, busy_o, done_o}, 64'd0);
    m_hi = 32'hDEAD_BEEF;
    issue(OP_MTLO, 32'h1357_9BDF, 32'd0);
    chk("mtlo", {hi_o, lo_o}, {m_hi, 32'h1357_9BDF});
    m_lo = 32'h1357_9BDF;
    issue(3'd6, 32'hFFFF_0000, 32'd1);
    chk("nop6", {hi_o, lo_o, 30'd0, busy_o, done_o}, {m_hi, m_lo, 32'd0} >> 0);

    // Second start during an operation is ignored.
    issue(OP_DIVU, 32'd100, 32'd7);
    lat = -1;
    for (int k = 1; k <= 60 && lat < 0; k++) begin
      @(posedge clk_i); #1;
      start_i = (k == 9);
      op_i = OP_MULTU; opa_i = 32'hFFFF_FFFF; opb_i = 32'hFFFF_FFFF;
      if (done_o) lat = k;
    end
    start_i = 1'b0;
    chk("busy ignore latency", 64'(lat), 64'd34);
    chk("busy ignore hi/lo", {hi_o, lo_o}, {32'd2, 32'd14});
    @(posedge clk_i); #1;
    chk("busy ignore idle", {62'd0, busy_o, done_o}, 64'd0);

    // Back-to-back: a start in the done cycle is accepted.
    issue(OP_MULTU, 32'd3, 32'd5);
    wait_done("b2b first", 32'd2, 32'd14, lat);
    chk("b2b first", {hi_o, lo_o}, {32'd0, 32'd15});
    issue(OP_DIV, 32'hFFFF_FF9C, 32'd7);   // -100 / 7 = -14 r -2
    wait_done("b2b second", 32'd0, 32'd15, lat);
    chk("b2b latency", 64'(lat), 64'd34);
    chk("b2b hi/lo", {hi_o, lo_o}, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    @(posedge clk_i); #1;

    // Reset in the middle of a divide aborts it.
    issue(OP_DIV, 32'd100, 32'd7);
    repeat (19) @(posedge clk_i);
    #1 reset_i = 1'b1;
    @(posedge clk_i); #1;
    reset_i = 1'b0;
    chk("abort state", {hi_o, lo_o, 31'd0, busy_o}, 96'd0 >> 0);
    ndone = 0;
    for (int k = 0; k < 50; k++) begin
      @(posedge clk_i); #1;
      if (done_o) ndone++;
    end
    chk("abort no done", 64'(ndone), 64'd0);
    chk("abort hi/lo stay", {hi_o, lo_o}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
